// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST sequencer.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WS   = 3'd1,
        WT   = 3'd2,
        WH   = 3'd3,
        RS   = 3'd4,
        RC   = 3'd5,
        DONE = 3'd6
    } op_state_e;

    // Bit 0 of the phase marks a read phase.
    localparam logic [1:0] PH_W0 = 2'd0;
    localparam logic [1:0] PH_R0 = 2'd1;
    localparam logic [1:0] PH_WP = 2'd2;
    localparam logic [1:0] PH_RP = 2'd3;

    localparam logic [7:0] ERR_MAX = 8'd255;

    // Data written (or expected) at an address in a given phase; caller truncates to DATA_W.
    function automatic logic [31:0] exp_data(input logic [1:0]  phase,
                                             input logic        addr_lsb,
                                             input logic [31:0] pattern);
        if (phase == PH_W0 || phase == PH_R0) begin
            return 32'd0;
        end
        return addr_lsb ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/mem_bist.sv
// Four-phase RAM self-test: write 0, read 0, write checkerboard, read checkerboard.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 5,
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'hAA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    op_state_e         state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

    logic              drv_en;
    logic [DATA_W-1:0] exp_val;
    logic [1:0]        phase_nxt;

    assign exp_val   = DATA_W'(exp_data(phase_q, addr_q[0], 32'(PATTERN)));
    assign phase_nxt = phase_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= PH_W0;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WS;
                    phase_d     = PH_W0;
                    addr_d      = '0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                end
            end
            WS: state_d = WT;
            WT: state_d = WH;
            RS: state_d = RC;
            WH, RC: begin
                if (state_q == RC && mem_data != exp_val) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (err_cnt_q == 8'd0) begin
                        fail_addr_d = addr_q;
                    end
                end
                if (addr_q == ADDR_LAST) begin
                    addr_d = '0;
                    if (phase_q == PH_RP) begin
                        state_d = DONE;
                    end else begin
                        phase_d = phase_nxt;
                        state_d = phase_nxt[0] ? RS : WS;
                    end
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = phase_q[0] ? RS : WS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == WS) || (state_q == WT) || (state_q == WH) ||
                    (state_q == RS) || (state_q == RC);
        done      = (state_q == DONE);
        pass      = (state_q == DONE) && (err_cnt_q == 8'd0);
        drv_en    = (state_q == WS) || (state_q == WT) || (state_q == WH);
        mem_write = (state_q == WT);
        mem_read  = (state_q == RS) || (state_q == RC);
        mem_addr  = addr_q;
        err_cnt   = err_cnt_q;
        fail_addr = fail_addr_q;
    end

    assign mem_data = drv_en ? exp_val : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: RAM model with stuck-at-1 faults, scoreboard of expected run results.
module tb_mem_bist;

    localparam logic [7:0] PAT = 8'hAA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, mem_read, mem_write;
    logic [7:0] err_cnt;
    logic [4:0] fail_addr, mem_addr;
    wire  [7:0] mem_data;

    logic       s_start = 1'b0;
    logic       s_busy, s_done, s_pass, s_read, s_write;
    logic [7:0] s_err;
    logic [7:0] s_fa, s_addr;
    wire  [7:0] s_data;

    mem_bist #(.ADDR_W(5), .DATA_W(8), .PATTERN(PAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
    );

    // Wide instance against a RAM that always reads 0xFF: enough mismatches to saturate.
    mem_bist #(.ADDR_W(8), .DATA_W(8), .PATTERN(PAT)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_cnt(s_err), .fail_addr(s_fa), .mem_addr(s_addr),
        .mem_read(s_read), .mem_write(s_write), .mem_data(s_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram   [32];
    logic [7:0] stuck [32];

    always @(posedge clk) if (mem_write) ram[mem_addr] <= mem_data;
    assign mem_data = mem_read ? (ram[mem_addr] | stuck[mem_addr]) : 8'bz;
    assign s_data   = s_read ? 8'hFF : 8'bz;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int         done_at;
        bit         pass;
        logic [7:0] err;
        logic [4:0] fa;
    } exp_t;
    exp_t exp_q[$];

    // Expected result of one run from the stuck-bit map: R0 sees 0|stuck, RP sees pat|stuck.
    task automatic push_exp(input int e);
        exp_t x;
        int n = 0;
        logic [7:0] want, got;
        x.fa = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < 32; a++) begin
                want = (ph == 0) ? 8'h00 : ((a % 2 == 1) ? ~PAT : PAT);
                got  = want | stuck[a];
                if (got !== want) begin
                    if (n == 0) x.fa = 5'(a);
                    n++;
                end
            end
        end
        x.err     = (n > 255) ? 8'd255 : 8'(n);
        x.pass    = (n == 0);
        x.done_at = e + 321;
        exp_q.push_back(x);
    endtask

    int   n_done = 0;
    int   wr_pulses = 0;
    int   bus_viol = 0;
    logic done_p = 1'b0, busy_p = 1'b0, mw_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_p) begin
            wr_pulses = 0;
            bus_viol  = 0;
        end
        if (mem_write && !mw_p) wr_pulses++;
        if (mem_write && mw_p) bus_viol++;
        if (mem_read && mem_write) bus_viol++;
        if (mem_read && u_dut.drv_en) bus_viol++;
        if (mem_write && !u_dut.drv_en) bus_viol++;
        if (u_dut.drv_en && !busy) bus_viol++;
        if (done && !done_p) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc + 1, e.done_at);
                chk("pass", int'(pass), int'(e.pass));
                chk("err_cnt", int'(err_cnt), int'(e.err));
                chk("fail_addr", int'(fail_addr), int'(e.fa));
                chk("write_pulses", wr_pulses, 64);
                chk("bus_violations", bus_viol, 0);
            end
        end
        done_p = done;
        busy_p = busy;
        mw_p   = mem_write;
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 700 && n_done < target; i++) @(negedge clk);
        chk("done_reached", int'(n_done >= target), 1);
    endtask

    task automatic do_run();
        int e, tgt;
        @(negedge clk);
        start = 1'b1;
        e   = cyc + 1;
        tgt = n_done + 1;
        push_exp(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(tgt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, tgt, bad;
        for (int a = 0; a < 32; a++) stuck[a] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_fail_addr", int'(fail_addr), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_strobes", int'({mem_read, mem_write}), 0);
        chk("rst_drv", int'(u_dut.drv_en), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean run with first write operation checked cycle by cycle.
        @(negedge clk);
        start = 1'b1;
        e   = cyc + 1;
        tgt = n_done + 1;
        push_exp(e);
        @(negedge clk);
        start = 1'b0;
        chk("e1_busy", int'(busy), 1);
        chk("e1_addr", int'(mem_addr), 0);
        chk("e1_write", int'(mem_write), 0);
        chk("e1_drv", int'(u_dut.drv_en), 1);
        @(negedge clk);
        chk("e2_write", int'(mem_write), 1);
        chk("e2_data", int'(mem_data), 0);
        @(negedge clk);
        chk("e3_write", int'(mem_write), 0);
        chk("e3_drv", int'(u_dut.drv_en), 1);
        @(negedge clk);
        chk("e4_addr", int'(mem_addr), 1);
        wait_done(tgt);
        bad = 0;
        for (int a = 0; a < 32; a++) if (ram[a] !== ((a % 2 == 1) ? 8'h55 : 8'hAA)) bad++;
        chk("ram_dump_bad_words", bad, 0);

        // Bit 0 of word 0x0A stuck high.
        stuck[10] = 8'h01;
        do_run();
        chk("w0a_err", int'(err_cnt), 2);
        chk("w0a_fail_addr", int'(fail_addr), 10);
        stuck[10] = 8'h00;

        // Reset mid-run, then a clean rerun.
        @(negedge clk);
        start = 1'b1;
        e = cyc + 1;
        push_exp(e);
        @(negedge clk);
        start = 1'b0;
        while (cyc < e + 99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_strobes", int'({mem_read, mem_write}), 0);
        chk("mrst_drv", int'(u_dut.drv_en), 0);
        chk("mrst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("mrst_hold_strobes", int'({mem_read, mem_write, u_dut.drv_en, busy}), 0);
        end
        rst_n = 1'b1;
        do_run();

        // Start held high: ignored while busy, restarts on the DONE cycle.
        @(negedge clk);
        start = 1'b1;
        e   = cyc + 1;
        tgt = n_done + 2;
        push_exp(e);
        push_exp(e + 321);
        while (cyc < e + 321) @(negedge clk);
        chk("hold_done_fell", int'(done), 0);
        chk("hold_busy", int'(busy), 1);
        while (cyc < e + 641) @(negedge clk);
        start = 1'b0;
        wait_done(tgt);
        @(negedge clk);
        chk("hold_no_third_run", int'(done), 1);

        // Randomized stuck-at-1 fault maps.
        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < 32; a++)
                stuck[a] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            do_run();
        end
        for (int a = 0; a < 32; a++) stuck[a] = 8'h00;

        // Saturation: 512 mismatching reads per run on the wide instance.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            s_start = 1'b1;
            e = cyc + 1;
            @(negedge clk);
            s_start = 1'b0;
            chk("sat_cleared_on_start", int'(s_err), 0);
            for (int i = 0; i < 3000 && !s_done; i++) @(negedge clk);
            chk("sat_done_cycle", cyc + 1, e + 2561);
            chk("sat_err", int'(s_err), 255);
            chk("sat_fail_addr", int'(s_fa), 0);
            chk("sat_pass", int'(s_pass), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
